// File: rtl/hist_accum.sv
`default_nettype none
// ============================================================================
// Module   : hist_accum
// Function : windowed histogram of sample MSBs, snapshotted per window and
//            scanned one bin per cycle for the index of the largest bin.
// Revision : 1.0 - initial release
// ============================================================================
module hist_accum #(
    parameter int DATA_WIDTH      = 16,
    parameter int SAMPLE_WIDTH    = 10,
    parameter int BOUND_NUM       = 32,
    parameter int BOUND_NUM_WIDTH = 5,
    parameter int WINDOW_LEN      = 1024
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            enable_i,
    input  logic                            sample_val_i,
    input  logic [SAMPLE_WIDTH-1:0]         sample_i,
    output logic                            data_val_o,
    output logic [DATA_WIDTH*BOUND_NUM-1:0] data_o,
    output logic [BOUND_NUM_WIDTH-1:0]      max_num_o
);

    localparam logic [1:0]                 c_IDLE     = 2'd0;
    localparam logic [1:0]                 c_SCAN     = 2'd1;
    localparam logic [1:0]                 c_DONE     = 2'd2;
    localparam logic [DATA_WIDTH-1:0]      c_SAT      = {DATA_WIDTH{1'b1}};
    localparam logic [DATA_WIDTH-1:0]      c_WIN_LAST = DATA_WIDTH'(WINDOW_LEN - 1);
    localparam logic [BOUND_NUM_WIDTH:0]   c_SCAN_END = (BOUND_NUM_WIDTH + 1)'(BOUND_NUM);

    logic                       w_accept;
    logic                       w_last;
    logic                       w_start;
    logic [BOUND_NUM_WIDTH-1:0] w_bin;
    logic [DATA_WIDTH-1:0]      w_next [BOUND_NUM];

    logic [DATA_WIDTH-1:0]      r_win_cnt;
    logic [DATA_WIDTH-1:0]      r_live [BOUND_NUM];
    logic [DATA_WIDTH-1:0]      r_snap [BOUND_NUM];

    logic [1:0]                 r_state;
    logic [BOUND_NUM_WIDTH:0]   r_scan_idx;
    logic [DATA_WIDTH-1:0]      r_cand;
    logic [BOUND_NUM_WIDTH-1:0] r_cand_idx;
    logic [DATA_WIDTH-1:0]      r_best_val;
    logic [BOUND_NUM_WIDTH-1:0] r_best_idx;
    logic [BOUND_NUM_WIDTH-1:0] r_max_num;
    logic                       w_cand_wins;

    assign w_accept = sample_val_i & enable_i;
    assign w_bin    = sample_i[SAMPLE_WIDTH-1 -: BOUND_NUM_WIDTH];
    assign w_last   = w_accept && (r_win_cnt == c_WIN_LAST);
    // A minimum-length window can close on the DONE cycle; DONE still pulses
    // and the next scan starts straight away.
    assign w_start  = w_last && (r_state != c_SCAN);

    generate
        if (SAMPLE_WIDTH > BOUND_NUM_WIDTH) begin : g_lsbs
            logic w_unused_lsbs;
            assign w_unused_lsbs = ^sample_i[SAMPLE_WIDTH-BOUND_NUM_WIDTH-1:0];
        end
    endgenerate

    generate
        for (genvar k = 0; k < BOUND_NUM; k++) begin : g_bin
            logic w_hit;
            assign w_hit     = w_accept && (w_bin == BOUND_NUM_WIDTH'(k));
            assign w_next[k] = (w_hit && (r_live[k] != c_SAT)) ? r_live[k] + DATA_WIDTH'(1)
                                                                : r_live[k];
            assign data_o[k*DATA_WIDTH +: DATA_WIDTH] = r_snap[k];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_win_cnt <= '0;
        end else if (w_accept) begin
            r_win_cnt <= w_last ? '0 : r_win_cnt + DATA_WIDTH'(1);
        end
    end

    // The closing sample's increment lands in the snapshot, not the new window.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < BOUND_NUM; k++) begin
                r_live[k] <= '0;
                r_snap[k] <= '0;
            end
        end else if (w_last) begin
            for (int k = 0; k < BOUND_NUM; k++) begin
                r_snap[k] <= w_next[k];
                r_live[k] <= '0;
            end
        end else begin
            for (int k = 0; k < BOUND_NUM; k++) begin
                r_live[k] <= w_next[k];
            end
        end
    end

    // Scan is pipelined: a bin is fetched one cycle and compared the next,
    // keeping the wide snapshot mux off the comparator path.
    assign w_cand_wins = r_cand > r_best_val;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= c_IDLE;
            r_scan_idx <= '0;
            r_cand     <= '0;
            r_cand_idx <= '0;
            r_best_val <= '0;
            r_best_idx <= '0;
            r_max_num  <= '0;
        end else if (w_start) begin
            r_state    <= c_SCAN;
            r_scan_idx <= '0;
            r_best_val <= '0;
            r_best_idx <= '0;
        end else begin
            case (r_state)
                c_SCAN: begin
                    if (r_scan_idx != '0 && w_cand_wins) begin
                        r_best_val <= r_cand;
                        r_best_idx <= r_cand_idx;
                    end
                    if (r_scan_idx != c_SCAN_END) begin
                        r_cand     <= r_snap[r_scan_idx[BOUND_NUM_WIDTH-1:0]];
                        r_cand_idx <= r_scan_idx[BOUND_NUM_WIDTH-1:0];
                        r_scan_idx <= r_scan_idx + (BOUND_NUM_WIDTH + 1)'(1);
                    end else begin
                        r_state   <= c_DONE;
                        r_max_num <= w_cand_wins ? r_cand_idx : r_best_idx;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign data_val_o = (r_state == c_DONE);
    assign max_num_o  = r_max_num;

    a_no_snap_in_scan: assert property (@(posedge clk) disable iff (reset)
        !(w_last && r_state == c_SCAN));

endmodule
`default_nettype wire

// File: tb/tb_hist_accum.sv
`default_nettype none
// Testbench for hist_accum: directed and random windows checked against a
// plain-arithmetic histogram model with expected pulse times.
module tb_hist_accum;

    localparam int DW  = 16;
    localparam int SW  = 10;
    localparam int BN  = 32;
    localparam int BNW = 5;
    localparam int WL  = 64;
    localparam int LAT = BN + 1;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              enable_i = 1'b0;
    logic              sample_val_i = 1'b0;
    logic [SW-1:0]     sample_i = '0;
    logic              data_val_o;
    logic [DW*BN-1:0]  data_o;
    logic [BNW-1:0]    max_num_o;

    hist_accum #(
        .DATA_WIDTH(DW), .SAMPLE_WIDTH(SW), .BOUND_NUM(BN),
        .BOUND_NUM_WIDTH(BNW), .WINDOW_LEN(WL)
    ) dut (
        .clk(clk), .reset(reset), .enable_i(enable_i), .sample_val_i(sample_val_i),
        .sample_i(sample_i), .data_val_o(data_val_o), .data_o(data_o), .max_num_o(max_num_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int passed = 0;

    // reference model
    int               m_hist [BN];
    int               m_cnt = 0;
    int               exp_cyc [$];
    logic [DW*BN-1:0] exp_data [$];
    int               exp_max [$];

    // observed pulses
    int               obs_cyc [$];
    logic [DW*BN-1:0] obs_data [$];
    int               obs_max [$];
    logic             have_pulse = 1'b0;
    logic [BNW-1:0]   held_max = '0;
    int               hold_bad = 0;

    always @(negedge clk) begin
        if (reset) begin
            have_pulse = 1'b0;
        end else if (data_val_o) begin
            obs_cyc.push_back(cyc);
            obs_data.push_back(data_o);
            obs_max.push_back(int'(max_num_o));
            have_pulse = 1'b1;
            held_max   = max_num_o;
        end else if (have_pulse && max_num_o !== held_max) begin
            hold_bad++;
        end
    end

    task automatic model_accept(input logic [SW-1:0] s, input int e);
        logic [DW*BN-1:0] v;
        int mx;
        int best;
        m_hist[int'(s) / (1 << (SW - BNW))]++;
        m_cnt++;
        if (m_cnt == WL) begin
            v  = '0;
            mx = 0;
            for (int k = 0; k < BN; k++) begin
                v[k*DW +: DW] = DW'(m_hist[k]);
                if (m_hist[k] > mx) mx = m_hist[k];
            end
            best = -1;
            for (int k = 0; k < BN; k++) if (best < 0 && m_hist[k] == mx) best = k;
            exp_cyc.push_back(e + LAT);
            exp_data.push_back(v);
            exp_max.push_back(best);
            for (int k = 0; k < BN; k++) m_hist[k] = 0;
            m_cnt = 0;
        end
    endtask

    task automatic step(input logic en, input logic val, input logic [SW-1:0] s);
        enable_i     = en;
        sample_val_i = val;
        sample_i     = s;
        @(posedge clk);
        #1;
        if (en && val && !reset) model_accept(s, cyc);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'($urandom_range(0, 1)), 1'b0, SW'($urandom));
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), SW'($urandom));
        reset = 1'b0;
        for (int k = 0; k < BN; k++) m_hist[k] = 0;
        m_cnt = 0;
        exp_cyc.delete(); exp_data.delete(); exp_max.delete();
        obs_cyc.delete(); obs_data.delete(); obs_max.delete();
        hold_bad = 0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) step(1'b1, 1'b1, SW'($urandom));
        checks++; if (data_val_o !== 1'b0) $display("FAIL reset_val: got %b want 0", data_val_o); else passed++;
        checks++; if (data_o !== '0) $display("FAIL reset_data: got %h want 0", data_o); else passed++;
        checks++; if (max_num_o !== '0) $display("FAIL reset_max: got %0d want 0", max_num_o); else passed++;
        do_reset(1);
    endtask

    task automatic test_single_bin;
        do_reset(1);
        repeat (WL) step(1'b1, 1'b1, 10'h2A5);
        idle(LAT + 8);
        checks++; if (obs_cyc.size() !== exp_cyc.size()) $display("FAIL single_pulses: got %0d want %0d", obs_cyc.size(), exp_cyc.size()); else passed++;
        for (int i = 0; i < exp_cyc.size() && i < obs_cyc.size(); i++) begin
            checks++; if (obs_cyc[i] !== exp_cyc[i]) $display("FAIL single_time[%0d]: got %0d want %0d", i, obs_cyc[i], exp_cyc[i]); else passed++;
            checks++; if (obs_data[i] !== exp_data[i]) $display("FAIL single_data[%0d]: got %h want %h", i, obs_data[i], exp_data[i]); else passed++;
        end
        checks++; if (obs_max.size() == 0 || obs_max[0] !== 21) $display("FAIL single_max: got %0d want 21", obs_max.size() ? obs_max[0] : -1); else passed++;
    endtask

    task automatic test_tie;
        do_reset(1);
        repeat (WL / 2) step(1'b1, 1'b1, 10'h060);
        repeat (WL / 2) step(1'b1, 1'b1, 10'h0E0);
        idle(LAT + 8);
        checks++; if (obs_cyc.size() !== exp_cyc.size()) $display("FAIL tie_pulses: got %0d want %0d", obs_cyc.size(), exp_cyc.size()); else passed++;
        for (int i = 0; i < exp_cyc.size() && i < obs_cyc.size(); i++) begin
            checks++; if (obs_data[i] !== exp_data[i]) $display("FAIL tie_data[%0d]: got %h want %h", i, obs_data[i], exp_data[i]); else passed++;
        end
        checks++; if (obs_max.size() == 0 || obs_max[0] !== 3) $display("FAIL tie_max: got %0d want 3", obs_max.size() ? obs_max[0] : -1); else passed++;
    endtask

    task automatic test_back_to_back;
        do_reset(1);
        repeat (WL) step(1'b1, 1'b1, 10'h000);
        repeat (WL) step(1'b1, 1'b1, 10'h3FF);
        idle(LAT + 8);
        checks++; if (obs_cyc.size() !== 2) $display("FAIL b2b_pulses: got %0d want 2", obs_cyc.size()); else passed++;
        for (int i = 0; i < exp_cyc.size() && i < obs_cyc.size(); i++) begin
            checks++; if (obs_cyc[i] !== exp_cyc[i]) $display("FAIL b2b_time[%0d]: got %0d want %0d", i, obs_cyc[i], exp_cyc[i]); else passed++;
            checks++; if (obs_data[i] !== exp_data[i]) $display("FAIL b2b_data[%0d]: got %h want %h", i, obs_data[i], exp_data[i]); else passed++;
            checks++; if (obs_max[i] !== exp_max[i]) $display("FAIL b2b_max[%0d]: got %0d want %0d", i, obs_max[i], exp_max[i]); else passed++;
        end
        if (obs_cyc.size() == 2) begin
            checks++; if (obs_cyc[1] - obs_cyc[0] !== WL) $display("FAIL b2b_spacing: got %0d want %0d", obs_cyc[1] - obs_cyc[0], WL); else passed++;
            checks++; if (obs_max[1] !== 31) $display("FAIL b2b_max31: got %0d want 31", obs_max[1]); else passed++;
        end
        checks++; if (hold_bad !== 0) $display("FAIL b2b_hold: got %0d changes want 0", hold_bad); else passed++;
    endtask

    task automatic test_gaps;
        int kind [$];
        int j;
        int t;
        do_reset(1);
        repeat (WL) kind.push_back(0);
        repeat (20) kind.push_back(1);
        repeat (15) kind.push_back(2);
        for (int i = kind.size() - 1; i > 0; i--) begin
            j = $urandom_range(i, 0);
            t = kind[i]; kind[i] = kind[j]; kind[j] = t;
        end
        foreach (kind[i]) begin
            case (kind[i])
                0:       step(1'b1, 1'b1, {5'd9, 5'($urandom)});
                1:       step(1'b0, 1'b1, SW'($urandom));
                default: step(1'b1, 1'b0, SW'($urandom));
            endcase
        end
        idle(LAT + 8);
        checks++; if (obs_cyc.size() !== 1) $display("FAIL gaps_pulses: got %0d want 1", obs_cyc.size()); else passed++;
        for (int i = 0; i < exp_cyc.size() && i < obs_cyc.size(); i++) begin
            checks++; if (obs_cyc[i] !== exp_cyc[i]) $display("FAIL gaps_time[%0d]: got %0d want %0d", i, obs_cyc[i], exp_cyc[i]); else passed++;
            checks++; if (obs_data[i] !== exp_data[i]) $display("FAIL gaps_data[%0d]: got %h want %h", i, obs_data[i], exp_data[i]); else passed++;
        end
        checks++; if (obs_max.size() == 0 || obs_max[0] !== 9) $display("FAIL gaps_max: got %0d want 9", obs_max.size() ? obs_max[0] : -1); else passed++;
    endtask

    task automatic test_reset_mid_window;
        do_reset(1);
        repeat (40) step(1'b1, 1'b1, {5'd2, 5'($urandom)});
        do_reset(1);
        repeat (WL) step(1'b1, 1'b1, {5'd5, 5'($urandom)});
        idle(LAT + 8);
        checks++; if (obs_cyc.size() !== 1) $display("FAIL midwin_pulses: got %0d want 1", obs_cyc.size()); else passed++;
        for (int i = 0; i < exp_cyc.size() && i < obs_cyc.size(); i++) begin
            checks++; if (obs_cyc[i] !== exp_cyc[i]) $display("FAIL midwin_time[%0d]: got %0d want %0d", i, obs_cyc[i], exp_cyc[i]); else passed++;
            checks++; if (obs_data[i] !== exp_data[i]) $display("FAIL midwin_data[%0d]: got %h want %h", i, obs_data[i], exp_data[i]); else passed++;
        end
        checks++; if (obs_max.size() == 0 || obs_max[0] !== 5) $display("FAIL midwin_max: got %0d want 5", obs_max.size() ? obs_max[0] : -1); else passed++;
    endtask

    task automatic test_reset_mid_scan;
        do_reset(1);
        repeat (WL) step(1'b1, 1'b1, {5'd7, 5'($urandom)});
        idle(10);
        do_reset(1);
        idle(LAT + 8);
        checks++; if (obs_cyc.size() !== 0) $display("FAIL midscan_pulses: got %0d want 0", obs_cyc.size()); else passed++;
        checks++; if (data_o !== '0) $display("FAIL midscan_data: got %h want 0", data_o); else passed++;
        checks++; if (max_num_o !== '0) $display("FAIL midscan_max: got %0d want 0", max_num_o); else passed++;
    endtask

    task automatic test_random;
        do_reset(2);
        repeat (300) step(1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 3) != 0), SW'($urandom));
        idle(LAT + 8);
        checks++; if (obs_cyc.size() !== exp_cyc.size()) $display("FAIL rand_pulses: got %0d want %0d", obs_cyc.size(), exp_cyc.size()); else passed++;
        for (int i = 0; i < exp_cyc.size() && i < obs_cyc.size(); i++) begin
            checks++; if (obs_cyc[i] !== exp_cyc[i]) $display("FAIL rand_time[%0d]: got %0d want %0d", i, obs_cyc[i], exp_cyc[i]); else passed++;
            checks++; if (obs_data[i] !== exp_data[i]) $display("FAIL rand_data[%0d]: got %h want %h", i, obs_data[i], exp_data[i]); else passed++;
            checks++; if (obs_max[i] !== exp_max[i]) $display("FAIL rand_max[%0d]: got %0d want %0d", i, obs_max[i], exp_max[i]); else passed++;
        end
        checks++; if (hold_bad !== 0) $display("FAIL rand_hold: got %0d changes want 0", hold_bad); else passed++;
    endtask

    initial begin
        for (int k = 0; k < BN; k++) m_hist[k] = 0;
        test_reset();
        test_single_bin();
        test_tie();
        test_back_to_back();
        test_gaps();
        test_reset_mid_window();
        test_reset_mid_scan();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", passed, checks);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
